// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and opcode constants for the fetch stage
package fetch_pkg;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } fetch_state_e;

   localparam logic [1:0] SEU_SEL_ALU = 2'b00;
   localparam logic [1:0] SEU_SEL_DT  = 2'b01;
   localparam logic [1:0] SEU_SEL_B   = 2'b10;
   localparam logic [1:0] SEU_SEL_CB  = 2'b11;

   localparam logic [5:0]  OPC_B     = 6'b000101;
   localparam logic [7:0]  OPC_CBZ   = 8'b10110100;
   localparam logic [7:0]  OPC_CBNZ  = 8'b10110101;
   localparam logic [7:0]  OPC_BCOND = 8'b01010100;
   localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
   localparam logic [10:0] OPC_STUR  = 11'b11111000000;

   localparam logic [63:0] INSN_BYTES = 64'd4;

endpackage

// File: rtl/fetch_unit_seu_sel_decode.sv
// rtl/fetch_unit_seu_sel_decode.sv - instruction word to sign-extension select
module seu_sel_decode
   import fetch_pkg::*;
(
   input  logic [31:0] insn,
   output logic [1:0]  sel
);

   always_comb begin
      sel = SEU_SEL_ALU;
      if (insn[31:26] == OPC_B) begin
         sel = SEU_SEL_B;
      end else if (insn[31:24] == OPC_CBZ || insn[31:24] == OPC_CBNZ ||
                   insn[31:24] == OPC_BCOND) begin
         sel = SEU_SEL_CB;
      end else if (insn[31:21] == OPC_LDUR || insn[31:21] == OPC_STUR) begin
         sel = SEU_SEL_DT;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch with IR, skid buffer and branch redirect
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0
)(
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic        branch_reg,
   input  logic [63:0] branch_offset,
   input  logic [63:0] branch_reg_target,
   output logic        ir_valid,
   output logic [31:0] ir,
   output logic [63:0] ir_pc,
   output logic [25:0] seu_addr,
   output logic [1:0]  seu_sel,
   output logic [63:0] pc
);

   fetch_state_e state_q, state_d;
   logic [63:0]  pc_q, pc_d;
   logic [63:0]  req_addr_q, req_addr_d;
   logic [63:0]  ir_pc_q, ir_pc_d;
   logic [63:0]  skid_pc_q, skid_pc_d;
   logic [31:0]  ir_q, ir_d;
   logic [31:0]  skid_q, skid_d;
   logic         ir_valid_q, ir_valid_d;
   logic         skid_valid_q, skid_valid_d;
   logic         kill_q, kill_d;
   logic         req_valid_q, req_valid_d;

   logic         redirect;
   logic         req_fire;
   logic         ir_free;
   logic [63:0]  redirect_pc;

   assign redirect    = branch_taken && ir_valid_q;
   assign req_fire    = req_valid_q && imem_req_ready;
   assign ir_free     = !ir_valid_q || !stall;
   assign redirect_pc = branch_reg ? branch_reg_target : ir_pc_q + (branch_offset << 2);

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_addr_d   = req_addr_q;
      ir_pc_d      = ir_pc_q;
      skid_pc_d    = skid_pc_q;
      ir_d         = ir_q;
      skid_d       = skid_q;
      ir_valid_d   = ir_valid_q;
      skid_valid_d = skid_valid_q;
      kill_d       = kill_q;

      if (ir_valid_q && !stall) begin
         ir_valid_d = 1'b0;
      end

      case (state_q)
         REQ: begin
            if (req_fire) begin
               state_d = WAIT;
               // pc already holds the redirect target once a kill is pending
               if (!kill_q && !redirect) begin
                  pc_d = pc_q + INSN_BYTES;
               end
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               state_d = REQ;
               kill_d  = 1'b0;
               if (!kill_q && !redirect) begin
                  if (ir_free) begin
                     ir_d       = imem_rsp_data;
                     ir_pc_d    = req_addr_q;
                     ir_valid_d = 1'b1;
                  end else begin
                     skid_d       = imem_rsp_data;
                     skid_pc_d    = req_addr_q;
                     skid_valid_d = 1'b1;
                     state_d      = HOLD;
                  end
               end
            end
         end
         HOLD: begin
            if (!stall) begin
               ir_d         = skid_q;
               ir_pc_d      = skid_pc_q;
               ir_valid_d   = 1'b1;
               skid_valid_d = 1'b0;
               state_d      = REQ;
            end
         end
         default: state_d = REQ;
      endcase

      if (redirect) begin
         pc_d         = redirect_pc;
         ir_valid_d   = 1'b0;
         skid_valid_d = 1'b0;
         case (state_q)
            REQ:     kill_d = 1'b1;
            // a response landing this same cycle is the one being dropped
            WAIT:    kill_d = !imem_rsp_valid;
            HOLD:    state_d = REQ;
            default: state_d = REQ;
         endcase
      end

      if (state_d == REQ && state_q != REQ) begin
         req_addr_d = pc_d;
      end
      req_valid_d = (state_d == REQ);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= REQ;
         pc_q         <= RESET_PC;
         req_addr_q   <= RESET_PC;
         ir_pc_q      <= 64'h0;
         skid_pc_q    <= 64'h0;
         ir_q         <= 32'h0;
         skid_q       <= 32'h0;
         ir_valid_q   <= 1'b0;
         skid_valid_q <= 1'b0;
         kill_q       <= 1'b0;
         req_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_addr_q   <= req_addr_d;
         ir_pc_q      <= ir_pc_d;
         skid_pc_q    <= skid_pc_d;
         ir_q         <= ir_d;
         skid_q       <= skid_d;
         ir_valid_q   <= ir_valid_d;
         skid_valid_q <= skid_valid_d;
         kill_q       <= kill_d;
         req_valid_q  <= req_valid_d;
      end
   end

   seu_sel_decode u_seu_sel_decode (
      .insn (ir_q),
      .sel  (seu_sel)
   );

   assign imem_req_valid = req_valid_q;
   assign imem_addr      = req_addr_q;
   assign ir_valid       = ir_valid_q;
   assign ir             = ir_q;
   assign ir_pc          = ir_pc_q;
   assign seu_addr       = ir_q[25:0];
   assign pc             = pc_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the sign-extension unit.
- Owns the 64-bit PC and issues one outstanding instruction-memory request at a time.
- Holds the fetched instruction in an instruction register (IR) with a one-entry skid buffer for downstream stalls.
- Presents IR[25:0] plus a decoded 2-bit extension select to the sign-extension unit.
- Consumes the sign-extended branch offset back from that unit to redirect the PC.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset (must be 4-byte aligned)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  64  fetch address, stable while imem_req_valid && !imem_req_ready
imem_rsp_valid  in  1  instruction word returned (no backpressure; exactly one per accepted request, ≥1 cycle after acceptance)
imem_rsp_data  in  32  instruction word
stall  in  1  downstream not consuming IR this cycle
branch_taken  in  1  redirect for the instruction currently in IR
branch_reg  in  1  with branch_taken: use branch_reg_target (BR) instead of PC-relative
branch_offset  in  64  sign-extended word offset from sign-extension unit
branch_reg_target  in  64  register branch target
ir_valid  out  1  IR holds a valid instruction
ir  out  32  instruction register
ir_pc  out  64  address of instruction in IR
seu_addr  out  26  ir[25:0]
seu_sel  out  2  extension select: 00 ALU imm, 01 DT addr, 10 B, 11 cond branch
pc  out  64  next fetch address

Behaviour:
- Reset (async):
  - pc=RESET_PC; ir, ir_pc, skid=0; ir_valid, skid_valid, kill=0.
  - imem_req_valid=0 while rst is high; state=REQ.
- States:
  - REQ: imem_req_valid=1, imem_addr=req_addr, where req_addr is latched from pc on entry to REQ. On imem_req_ready: pc<=pc+4 (mod 2^64), go to WAIT.
  - WAIT: wait for imem_rsp_valid.
    - If kill=1: drop the word, clear kill, go to REQ.
    - Else if IR free (ir_valid=0, or ir_valid && !stall): load IR, ir_pc<=req_addr, ir_valid<=1, go to REQ.
    - Else: load skid, go to HOLD.
  - HOLD: no request issued. When !stall: skid moves to IR, go to REQ.
- IR consumption: an IR entry is consumed on any cycle with ir_valid && !stall; ir_valid drops unless refilled the same cycle. Fetch-to-IR latency is 1 cycle after imem_rsp_valid.
- Redirect: branch_taken is qualified by ir_valid and ignored otherwise. It has priority over stall and over a same-cycle response. Next cycle:
  - ir_valid=0 and skid_valid=0.
  - pc <= branch_reg ? branch_reg_target : ir_pc + {branch_offset[61:0],2'b00}, mod 2^64.
  - In WAIT, or in REQ (accepted or not): kill<=1. A REQ not yet accepted holds its address until accepted, then its response is dropped.
  - From HOLD: go to REQ.
  - The redirected fetch issues only after any killed response has returned.
- seu_sel decode (combinational from ir):
  - ir[31:26]=000101 (B) -> 10.
  - ir[31:24] in {10110100, 10110101, 01010100} (CBZ, CBNZ, B.cond) -> 11.
  - ir[31:21] in {11111000010, 11111000000} (LDUR, STUR) -> 01.
  - Otherwise -> 00.
- seu_addr=ir[25:0]; both outputs are 0 after reset.
- Simultaneous events:
  - imem_rsp_valid with redirect -> word dropped.
  - imem_req_ready with redirect -> handshake completes, kill set.
- Reset mid-transaction: all state cleared. A response arriving after reset deasserts with no outstanding request is ignored, since the unit is in REQ.

Decomposition:
- Package fetch_pkg:
  - State enum {REQ, WAIT, HOLD}.
  - SEU_SEL_* constants (00/01/10/11).
  - Opcode match constants for B, CBZ, CBNZ, B.cond, LDUR, STUR.
  - INSN_BYTES=4.
- One natural sub-module, seu_sel_decode: IR to seu_sel, purely combinational.

Test Plan:
- Reset with RESET_PC=0x100, ready tied 1, rsp 1 cycle later, stall=0 -> imem_addr sequence 0x100, 0x104, 0x108; ir_pc follows one response behind; pc=0x10C after third accept.
- IR=0x14000003 (B +3) at ir_pc=0x200, branch_offset=3, branch_taken=1 -> seu_sel=10, seu_addr=0x0000003; next pc=0x20C, in-flight response dropped, next ir_pc=0x20C.
- Offset=64'hFFFF_FFFF_FFFF_FFFE at ir_pc=0x10 -> target 0x08. Offset -8 at ir_pc=0x10 -> target wraps to 0xFFFF_FFFF_FFFF_FFF0.
- stall=1 for 5 cycles while a response arrives -> word held in skid, no new imem_req_valid; stall drops -> word appears in IR the next cycle, fetch resumes.
- imem_req_ready held 0 for 3 cycles, branch_taken pulses -> imem_addr unchanged until accepted, that response discarded, then the branch target is requested.
- Assert rst during WAIT -> ir_valid=0, pc=RESET_PC, late rsp ignored, first request after release at RESET_PC.
